player_jump_controller: RTL

// Per-frame position generator for the player sprite. Sits directly upstream of the rectangle/bitmap

---
 rtl/player_pkg.sv | 20 ++
 rtl/player_jump_controller.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/player_pkg.sv
// Shared types and fixed-point helpers for the player sprite position controller.
package player_pkg;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    AIR    = 2'd1,
    HIT    = 2'd2
  } player_state_t;

  localparam int FIXED_SHIFT = 6;
  localparam int PIXEL_W     = 11;

  // Whole-pixel view of a x64 fixed-point coordinate, truncated to the output width.
  function automatic logic [PIXEL_W-1:0] to_pixel(input logic signed [31:0] fx);
    logic signed [31:0] px;
    px = fx >>> FIXED_SHIFT;
    return px[PIXEL_W-1:0];
  endfunction

endpackage

// File: rtl/player_jump_controller.sv
// Per-frame player sprite position: keyboard walk, jump with gravity and a timed collision freeze.
// State advances only on startOfFrame; all outputs are registered.
module player_jump_controller
  import player_pkg::*;
#(
  parameter int INITIAL_X  = 64,
  parameter int GROUND_Y   = 400,
  parameter int X_MIN      = 0,
  parameter int X_MAX      = 608,
  parameter int X_SPEED    = 2,
  parameter int JUMP_SPEED = -640,
  parameter int GRAVITY    = 32,
  parameter int HIT_FRAMES = 60
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               leftKey,
  input  logic               rightKey,
  input  logic               jumpKey,
  input  logic               collision,
  output logic [PIXEL_W-1:0] topLeftX,
  output logic [PIXEL_W-1:0] topLeftY,
  output logic               inAir,
  output logic               hit
);

  localparam int FX_ONE = 1 << FIXED_SHIFT;
  localparam int HIT_W  = $clog2(HIT_FRAMES + 1);

  localparam logic signed [31:0] X_INIT_FX = 32'(INITIAL_X * FX_ONE);
  localparam logic signed [31:0] GROUND_FX = 32'(GROUND_Y * FX_ONE);
  localparam logic signed [31:0] X_MIN_FX  = 32'(X_MIN * FX_ONE);
  localparam logic signed [31:0] X_MAX_FX  = 32'(X_MAX * FX_ONE);
  localparam logic signed [31:0] X_STEP_FX = 32'(X_SPEED * FX_ONE);
  localparam logic signed [31:0] JUMP_FX   = 32'(JUMP_SPEED);
  localparam logic signed [31:0] GRAV_FX   = 32'(GRAVITY);
  localparam logic [HIT_W-1:0]   HIT_INIT  = HIT_W'(HIT_FRAMES);

  player_state_t      state_q, state_d;
  logic signed [31:0] x_q, x_d;
  logic signed [31:0] y_q, y_d;
  logic signed [31:0] v_q, v_d;
  logic [HIT_W-1:0]   hit_cnt_q, hit_cnt_d;

  logic [PIXEL_W-1:0] top_left_x_q;
  logic [PIXEL_W-1:0] top_left_y_q;
  logic               in_air_q;
  logic               hit_q;

  logic signed [31:0] x_step_s;
  logic signed [31:0] x_walk_s;
  logic signed [31:0] x_clamp_s;
  logic signed [31:0] y_air_s;

  // Walk step, clamp and the per-frame FSM / kinematics update.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    v_d       = v_q;
    hit_cnt_d = hit_cnt_q;
    y_air_s   = y_q + v_q;

    if (rightKey && !leftKey) begin
      x_step_s = X_STEP_FX;
    end else if (leftKey && !rightKey) begin
      x_step_s = -X_STEP_FX;
    end else begin
      x_step_s = 32'sd0;
    end
    x_walk_s = x_q + x_step_s;

    if (x_walk_s > X_MAX_FX) begin
      x_clamp_s = X_MAX_FX;
    end else if (x_walk_s < X_MIN_FX) begin
      x_clamp_s = X_MIN_FX;
    end else begin
      x_clamp_s = x_walk_s;
    end

    if (startOfFrame) begin
      case (state_q)
        GROUND: begin
          // Walking still applies on the tick a collision is taken.
          x_d = x_clamp_s;
          if (collision) begin
            state_d   = HIT;
            hit_cnt_d = HIT_INIT;
          end else if (jumpKey) begin
            state_d = AIR;
            v_d     = JUMP_FX;
          end else begin
            state_d = GROUND;
          end
        end
        AIR: begin
          x_d = x_clamp_s;
          if (collision) begin
            state_d   = HIT;
            v_d       = 32'sd0;
            hit_cnt_d = HIT_INIT;
          end else if (y_air_s >= GROUND_FX) begin
            state_d = GROUND;
            y_d     = GROUND_FX;
            v_d     = 32'sd0;
          end else begin
            y_d = y_air_s;
            v_d = v_q + GRAV_FX;
          end
        end
        HIT: begin
          hit_cnt_d = hit_cnt_q - HIT_W'(1);
          if (hit_cnt_q <= HIT_W'(1)) begin
            state_d   = GROUND;
            y_d       = GROUND_FX;
            v_d       = 32'sd0;
            hit_cnt_d = '0;
          end else begin
            state_d = HIT;
          end
        end
        default: begin
          state_d   = GROUND;
          y_d       = GROUND_FX;
          v_d       = 32'sd0;
          hit_cnt_d = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State, datapath and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q      <= GROUND;
      x_q          <= X_INIT_FX;
      y_q          <= GROUND_FX;
      v_q          <= 32'sd0;
      hit_cnt_q    <= '0;
      top_left_x_q <= to_pixel(X_INIT_FX);
      top_left_y_q <= to_pixel(GROUND_FX);
      in_air_q     <= 1'b0;
      hit_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      v_q          <= v_d;
      hit_cnt_q    <= hit_cnt_d;
      top_left_x_q <= to_pixel(x_d);
      top_left_y_q <= to_pixel(y_d);
      in_air_q     <= (state_d == AIR);
      hit_q        <= (state_d == HIT);
    end
  end

  assign topLeftX = top_left_x_q;
  assign topLeftY = top_left_y_q;
  assign inAir    = in_air_q;
  assign hit      = hit_q;

endmodule
